// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiply/divide-register unit.
//   MUL_WIDTH / MUL_ITER : operand width and number of shift-add iterations
//   prod_t               : double-width product
//   state_t              : sequencer states
//   wb_op_t              : write-back flavour latched at accept
//   FUNC_*               : decoder function codes (SPECIAL and SPECIAL2 groups)
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;
   localparam int unsigned MUL_ITER  = 32;
   localparam int unsigned CNT_W     = $clog2(MUL_ITER);

   typedef logic [2*MUL_WIDTH-1:0] prod_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

   typedef enum logic [1:0] {
      OP_MULT,
      OP_MADD,
      OP_MSUB,
      OP_MUL
   } wb_op_t;

   // Function codes mirror the decoder's alu/mul definitions.
   // SPECIAL group (mul_op = 0)
   localparam logic [5:0] FUNC_MFHI  = 6'h10;
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MFLO  = 6'h12;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   // SPECIAL2 group (mul_op = 1)
   localparam logic [5:0] FUNC_MADD  = 6'h00;
   localparam logic [5:0] FUNC_MADDU = 6'h01;
   localparam logic [5:0] FUNC_MUL   = 6'h02;
   localparam logic [5:0] FUNC_MSUB  = 6'h04;
   localparam logic [5:0] FUNC_MSUBU = 6'h05;

endpackage

// File: rtl/mul_seq_unit_if.sv
// Request/response bundle between the decode stage and mul_seq_unit.
//   master : decoder side, drives start/mul_op/func/a/b
//   slave  : multiply unit, drives busy/stall/done/rd_data/hi/lo
interface mul_seq_unit_if;
   import mul_pkg::*;

   logic                 start;
   logic                 mul_op;
   logic [5:0]           func;
   logic [MUL_WIDTH-1:0] a;
   logic [MUL_WIDTH-1:0] b;
   logic                 busy;
   logic                 stall;
   logic                 done;
   logic [MUL_WIDTH-1:0] rd_data;
   logic [MUL_WIDTH-1:0] hi;
   logic [MUL_WIDTH-1:0] lo;

   modport master (
      output start, mul_op, func, a, b,
      input  busy, stall, done, rd_data, hi, lo
   );

   modport slave (
      input  start, mul_op, func, a, b,
      output busy, stall, done, rd_data, hi, lo
   );

endinterface

// File: rtl/mul_core.sv
// Radix-2 shift-add multiplier datapath.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture operand magnitudes and result sign, clear accumulator
//   step     : one multiplier bit per cycle
//   sgn      : operands are two's complement (sampled with load)
//   a, b     : operands
//   product  : signed/unsigned 64-bit result, valid after MUL_ITER steps
module mul_core
   import mul_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic                 sgn,
   input  logic [MUL_WIDTH-1:0] a,
   input  logic [MUL_WIDTH-1:0] b,
   output prod_t                product
);

   prod_t                mcand_q, mcand_d;
   prod_t                acc_q, acc_d;
   logic [MUL_WIDTH-1:0] mplier_q, mplier_d;
   logic                 neg_q, neg_d;
   logic [MUL_WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      a_mag    = (sgn && a[MUL_WIDTH-1]) ? -a : a;
      b_mag    = (sgn && b[MUL_WIDTH-1]) ? -b : b;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      if (load) begin
         mcand_d  = {{MUL_WIDTH{1'b0}}, a_mag};
         mplier_d = b_mag;
         acc_d    = '0;
         neg_d    = sgn & (a[MUL_WIDTH-1] ^ b[MUL_WIDTH-1]);
      end else if (step) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
      end
   end

   // Magnitude product re-signed on the way out.
   assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential HI/LO multiply unit: MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL over
// 32 shift-add cycles, plus single-cycle MFHI/MFLO/MTHI/MTLO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mul_seq_unit_if (request in, busy/stall/done,
//              rd_data and architectural hi/lo out)
module mul_seq_unit
   import mul_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   mul_seq_unit_if.slave  bus
);

   state_t               state_q, state_d;
   wb_op_t               op_q, op_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [MUL_WIDTH-1:0] hi_q, hi_d;
   logic [MUL_WIDTH-1:0] lo_q, lo_d;
   logic [MUL_WIDTH-1:0] rd_q, rd_d;
   logic                 done_q, done_d;

   logic is_mult, is_multu, is_madd, is_maddu, is_msub, is_msubu, is_mul;
   logic is_mfhi, is_mflo, is_mthi, is_mtlo;
   logic mul_class, signed_op;
   logic busy;
   logic core_load, core_step;
   prod_t product;

   always_comb begin
      is_mfhi   = !bus.mul_op && (bus.func == FUNC_MFHI);
      is_mflo   = !bus.mul_op && (bus.func == FUNC_MFLO);
      is_mthi   = !bus.mul_op && (bus.func == FUNC_MTHI);
      is_mtlo   = !bus.mul_op && (bus.func == FUNC_MTLO);
      is_mult   = !bus.mul_op && (bus.func == FUNC_MULT);
      is_multu  = !bus.mul_op && (bus.func == FUNC_MULTU);
      is_madd   =  bus.mul_op && (bus.func == FUNC_MADD);
      is_maddu  =  bus.mul_op && (bus.func == FUNC_MADDU);
      is_msub   =  bus.mul_op && (bus.func == FUNC_MSUB);
      is_msubu  =  bus.mul_op && (bus.func == FUNC_MSUBU);
      is_mul    =  bus.mul_op && (bus.func == FUNC_MUL);
      mul_class = is_mult | is_multu | is_madd | is_maddu |
                  is_msub | is_msubu | is_mul;
      signed_op = is_mult | is_madd | is_msub | is_mul;
   end

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      rd_d      = rd_q;
      done_d    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (mul_class) begin
                  core_load = 1'b1;
                  count_d   = '0;
                  state_d   = CALC;
                  if (is_mult || is_multu)      op_d = OP_MULT;
                  else if (is_madd || is_maddu) op_d = OP_MADD;
                  else if (is_msub || is_msubu) op_d = OP_MSUB;
                  else                          op_d = OP_MUL;
               end else if (is_mthi) begin
                  hi_d = bus.a;
               end else if (is_mtlo) begin
                  lo_d = bus.a;
               end else if (is_mfhi) begin
                  rd_d = hi_q;
               end else if (is_mflo) begin
                  rd_d = lo_q;
               end
            end
         end
         CALC: begin
            core_step = 1'b1;
            count_d   = count_q + 1'b1;
            if (count_q == CNT_W'(MUL_ITER - 1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            case (op_q)
               OP_MULT: {hi_d, lo_d} = product;
               OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + product;
               OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - product;
               OP_MUL:  rd_d = product[MUL_WIDTH-1:0];
               default: ;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_MULT;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rd_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
      end
   end

   mul_core u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (core_load),
      .step    (core_step),
      .sgn     (signed_op),
      .a       (bus.a),
      .b       (bus.b),
      .product (product)
   );

   assign bus.busy    = busy;
   assign bus.stall   = bus.start & busy;
   assign bus.done    = done_q;
   assign bus.rd_data = rd_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_mul_seq_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mul_seq_unit_if bus();

   mul_seq_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_MADD  = 6'h00;
   localparam logic [5:0] F_MADDU = 6'h01;
   localparam logic [5:0] F_MUL   = 6'h02;
   localparam logic [5:0] F_MSUB  = 6'h04;
   localparam logic [5:0] F_MSUBU = 6'h05;
   localparam logic [5:0] F_BAD   = 6'h3F;

   localparam int K_SET = 0;
   localparam int K_ADD = 1;
   localparam int K_SUB = 2;
   localparam int K_RD  = 3;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;
   logic chk_en   = 1'b0;

   // Reference model state
   logic [31:0] m_hi, m_lo, m_rd;
   logic        m_done;
   int          m_cnt;
   int          m_kind;
   logic [63:0] m_prod;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input logic [31:0] dutv, input logic [31:0] modv,
                      input logic [31:0] expv);
      check(name, dutv, expv);
      check({name, "_model"}, modv, expv);
   endtask

   // Model: a multiply-class request completes 33 edges after acceptance,
   // using the full-width arithmetic product.
   always @(posedge clk) begin : model
      logic [63:0] sp, up, acc;
      logic [31:0] av, bv;
      if (rst) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_rd   <= '0;
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_done <= 1'b1;
               acc = {m_hi, m_lo};
               case (m_kind)
                  K_SET:   {m_hi, m_lo} <= m_prod;
                  K_ADD:   {m_hi, m_lo} <= acc + m_prod;
                  K_SUB:   {m_hi, m_lo} <= acc - m_prod;
                  default: m_rd <= m_prod[31:0];
               endcase
            end
         end else if (bus.start) begin
            av = bus.a;
            bv = bus.b;
            sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
            up = {32'h0, av} * {32'h0, bv};
            if (!bus.mul_op) begin
               case (bus.func)
                  F_MFHI:  m_rd <= m_hi;
                  F_MFLO:  m_rd <= m_lo;
                  F_MTHI:  m_hi <= av;
                  F_MTLO:  m_lo <= av;
                  F_MULT:  begin m_kind <= K_SET; m_prod <= sp; m_cnt <= 33; end
                  F_MULTU: begin m_kind <= K_SET; m_prod <= up; m_cnt <= 33; end
                  default: ;
               endcase
            end else begin
               case (bus.func)
                  F_MADD:  begin m_kind <= K_ADD; m_prod <= sp; m_cnt <= 33; end
                  F_MADDU: begin m_kind <= K_ADD; m_prod <= up; m_cnt <= 33; end
                  F_MSUB:  begin m_kind <= K_SUB; m_prod <= sp; m_cnt <= 33; end
                  F_MSUBU: begin m_kind <= K_SUB; m_prod <= up; m_cnt <= 33; end
                  F_MUL:   begin m_kind <= K_RD;  m_prod <= sp; m_cnt <= 33; end
                  default: ;
               endcase
            end
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",    32'(bus.busy),  32'(m_cnt != 0));
         check("stall",   32'(bus.stall), 32'(bus.start & (m_cnt != 0)));
         check("done",    32'(bus.done),  32'(m_done));
         check("hi",      bus.hi,         m_hi);
         check("lo",      bus.lo,         m_lo);
         check("rd_data", bus.rd_data,    m_rd);
         if (bus.done === 1'b1) n_done++;
      end
   end

   // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
   task automatic issue(input logic mop, input logic [5:0] f, input logic [31:0] av,
                        input logic [31:0] bv, output int stalls);
      bit acc;
      int n;
      bus.start  = 1'b1;
      bus.mul_op = mop;
      bus.func   = f;
      bus.a      = av;
      bus.b      = bv;
      stalls     = 0;
      n          = 0;
      acc        = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = !bus.busy;
         if (!acc) stalls++;
         @(posedge clk);
         #2;
         n++;
      end
      if (!acc) check("accept_timeout", 32'(bus.busy), 32'd0);
      bus.start  = 1'b0;
      // Scramble inputs so an in-flight operation must rely on latched values.
      bus.a      = $urandom;
      bus.b      = $urandom;
      bus.func   = 6'($urandom);
      bus.mul_op = 1'($urandom);
   endtask

   // Counts busy cycles, returns at posedge+2 after the first idle cycle.
   task automatic wait_idle(output int nb);
      nb = 0;
      @(negedge clk);
      while (bus.busy && nb < 200) begin
         nb++;
         @(negedge clk);
      end
      if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, nb, d0;
      logic [31:0] s_hi, s_lo, s_rd;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.mul_op = 1'b0;
      bus.func   = '0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (3) @(posedge clk);
      #2;
      rst    = 1'b0;
      chk_en = 1'b1;

      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      lit("reset_hi", bus.hi, m_hi, 32'h0);
      lit("reset_lo", bus.lo, m_lo, 32'h0);
      lit("reset_rd", bus.rd_data, m_rd, 32'h0);

      // MULT -2 * 3
      d0 = n_done;
      issue(1'b0, F_MULT, 32'hFFFF_FFFE, 32'd3, st);
      wait_idle(nb);
      check("mult_busy_cycles", 32'(nb), 32'd33);
      check("mult_done_pulses", 32'(n_done - d0), 32'd1);
      lit("mult_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
      lit("mult_lo", bus.lo, m_lo, 32'hFFFF_FFFA);

      // MULTU max * max
      issue(1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
      wait_idle(nb);
      lit("multu_hi", bus.hi, m_hi, 32'hFFFF_FFFE);
      lit("multu_lo", bus.lo, m_lo, 32'h0000_0001);

      // MTHI/MTLO then MADD / MSUB
      d0 = n_done;
      issue(1'b0, F_MTHI, 32'd0, 32'd0, st);
      issue(1'b0, F_MTLO, 32'd10, 32'd0, st);
      wait_idle(nb);
      check("mtx_busy_cycles", 32'(nb), 32'd0);
      check("mtx_no_done", 32'(n_done - d0), 32'd0);
      lit("mtlo_lo", bus.lo, m_lo, 32'd10);
      issue(1'b1, F_MADD, 32'd4, 32'd5, st);
      wait_idle(nb);
      lit("madd_lo", bus.lo, m_lo, 32'd30);
      lit("madd_hi", bus.hi, m_hi, 32'd0);
      issue(1'b1, F_MSUB, 32'd1, 32'd31, st);
      wait_idle(nb);
      lit("msub_lo", bus.lo, m_lo, 32'hFFFF_FFFF);
      lit("msub_hi", bus.hi, m_hi, 32'hFFFF_FFFF);

      // MFHI, MFLO
      issue(1'b0, F_MTLO, 32'h1234_5678, 32'd0, st);
      issue(1'b0, F_MFLO, 32'd0, 32'd0, st);
      lit("mflo_rd", bus.rd_data, m_rd, 32'h1234_5678);
      issue(1'b0, F_MFHI, 32'd0, 32'd0, st);
      lit("mfhi_rd", bus.rd_data, m_rd, 32'hFFFF_FFFF);

      // MUL: low word to rd_data, hi/lo untouched
      issue(1'b1, F_MUL, 32'hFFFF_FFFD, 32'd7, st);
      wait_idle(nb);
      lit("mul_neg_rd", bus.rd_data, m_rd, 32'hFFFF_FFEB);
      lit("mul_neg_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
      lit("mul_neg_lo", bus.lo, m_lo, 32'h1234_5678);
      issue(1'b1, F_MUL, 32'h0001_0000, 32'h0001_0000, st);
      wait_idle(nb);
      lit("mul_wrap_rd", bus.rd_data, m_rd, 32'h0);
      lit("mul_wrap_hi", bus.hi, m_hi, 32'hFFFF_FFFF);

      // Request held while busy: stalls for every busy cycle, then accepted
      issue(1'b1, F_MUL, 32'd6, 32'd7, st);
      issue(1'b0, F_MFLO, 32'd0, 32'd0, st);
      check("held_stall_cycles", 32'(st), 32'd33);
      lit("held_mflo_rd", bus.rd_data, m_rd, 32'h1234_5678);

      // Illegal function codes change nothing
      s_hi = bus.hi; s_lo = bus.lo; s_rd = bus.rd_data;
      issue(1'b0, F_BAD, 32'hDEAD_BEEF, 32'h5, st);
      issue(1'b1, F_BAD, 32'hDEAD_BEEF, 32'h5, st);
      wait_idle(nb);
      check("illegal_busy_cycles", 32'(nb), 32'd0);
      check("illegal_hi", bus.hi, s_hi);
      check("illegal_lo", bus.lo, s_lo);
      check("illegal_rd", bus.rd_data, s_rd);

      // Back-to-back MADD chain sees the first result
      issue(1'b0, F_MTHI, 32'd0, 32'd0, st);
      issue(1'b0, F_MTLO, 32'd0, 32'd0, st);
      issue(1'b1, F_MADD, 32'd3, 32'd4, st);
      issue(1'b1, F_MADD, 32'd5, 32'd6, st);
      check("chain_stall_cycles", 32'(st), 32'd33);
      wait_idle(nb);
      check("chain_busy_cycles", 32'(nb), 32'd33);
      lit("chain_lo", bus.lo, m_lo, 32'd42);
      lit("chain_hi", bus.hi, m_hi, 32'd0);

      // Unsigned accumulate/subtract with carry/borrow across the word
      issue(1'b1, F_MADDU, 32'hFFFF_FFFF, 32'd2, st);
      wait_idle(nb);
      lit("maddu_hi", bus.hi, m_hi, 32'h2);
      lit("maddu_lo", bus.lo, m_lo, 32'h28);
      issue(1'b1, F_MSUBU, 32'd1, 32'h29, st);
      wait_idle(nb);
      lit("msubu_hi", bus.hi, m_hi, 32'h1);
      lit("msubu_lo", bus.lo, m_lo, 32'hFFFF_FFFF);

      // Most-negative operand corners
      issue(1'b0, F_MULT, 32'h8000_0000, 32'h8000_0000, st);
      wait_idle(nb);
      lit("mult_minmin_hi", bus.hi, m_hi, 32'h4000_0000);
      lit("mult_minmin_lo", bus.lo, m_lo, 32'h0);
      issue(1'b0, F_MULT, 32'h8000_0000, 32'd1, st);
      wait_idle(nb);
      lit("mult_min1_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
      lit("mult_min1_lo", bus.lo, m_lo, 32'h8000_0000);
      issue(1'b1, F_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
      wait_idle(nb);
      lit("madd_negneg_lo", bus.lo, m_lo, 32'h8000_0001);

      // Reset at iteration 10 of MULT 7*9
      issue(1'b0, F_MTHI, 32'd5, 32'd0, st);
      issue(1'b0, F_MTLO, 32'd6, 32'd0, st);
      d0 = n_done;
      issue(1'b0, F_MULT, 32'd7, 32'd9, st);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      lit("abort_hi", bus.hi, m_hi, 32'h0);
      lit("abort_lo", bus.lo, m_lo, 32'h0);
      repeat (40) @(posedge clk);
      #2;
      check("abort_no_done", 32'(n_done - d0), 32'd0);
      lit("abort_hi_later", bus.hi, m_hi, 32'h0);

      // Reset landing on the FIN edge
      d0 = n_done;
      issue(1'b0, F_MULT, 32'd7, 32'd9, st);
      repeat (32) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("fin_abort_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      check("fin_abort_no_done", 32'(n_done - d0), 32'd0);
      lit("fin_abort_lo", bus.lo, m_lo, 32'h0);

      // Reset wins over a same-edge start
      rst        = 1'b1;
      bus.start  = 1'b1;
      bus.mul_op = 1'b0;
      bus.func   = F_MTHI;
      bus.a      = 32'h5;
      @(posedge clk);
      #2;
      bus.func   = F_MULT;
      @(posedge clk);
      #2;
      rst        = 1'b0;
      bus.start  = 1'b0;
      check("rst_prio_busy", 32'(bus.busy), 32'd0);
      lit("rst_prio_hi", bus.hi, m_hi, 32'h0);

      // Normal operation resumes after reset
      issue(1'b0, F_MULTU, 32'd7, 32'd9, st);
      wait_idle(nb);
      lit("post_rst_lo", bus.lo, m_lo, 32'd63);

      repeat (2) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
